// File: rtl/fetch_sequencer.sv
// Front-end pipeline control: sequences fetch/decode enables, flushes and branch
// redirects through start, run, branch flush, memory stall, halt drain and halted.
module fetch_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 halt_detect,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 hazard_load,
    input  logic                 ext_stall,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 branch_flag,
    output logic [31:0]          branch_addr,
    output logic                 running,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, STALL, DRAIN, HALTED} state_t;

    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);
    // A single wrong-path slot is fully covered by the branch cycle's own flushes.
    localparam state_t BRANCH_NEXT = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

    state_t      state, state_next;
    logic [15:0] flush_cnt, flush_cnt_next;
    logic [15:0] drain_cnt, drain_cnt_next;
    logic        stall_inc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            drain_cnt <= drain_cnt_next;
            if (stall_inc)
                stall_count <= sat_inc(stall_count);
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        drain_cnt_next = drain_cnt;
        stall_inc      = 1'b0;
        fetch_en       = 1'b0;
        decode_en      = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        branch_flag    = 1'b0;
        running        = 1'b0;
        halted         = 1'b0;

        case (state)
            IDLE: begin
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                running   = 1'b1;
                fetch_en  = 1'b1;
                decode_en = 1'b1;
                if (branch_taken) begin
                    branch_flag    = 1'b1;
                    flush_if_id    = 1'b1;
                    flush_id_ex    = 1'b1;
                    state_next     = BRANCH_NEXT;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (ext_stall) begin
                    fetch_en   = 1'b0;
                    decode_en  = 1'b0;
                    state_next = STALL;
                end else if (hazard_load) begin
                    fetch_en    = 1'b0;
                    decode_en   = 1'b0;
                    flush_id_ex = 1'b1;
                    stall_inc   = 1'b1;
                end else if (halt_detect) begin
                    fetch_en       = 1'b0;
                    flush_if_id    = 1'b1;
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            FLUSH: begin
                // Halt and load-use requests here come from wrong-path instructions.
                running     = 1'b1;
                fetch_en    = 1'b1;
                decode_en   = 1'b1;
                flush_if_id = 1'b1;
                if (branch_taken) begin
                    branch_flag    = 1'b1;
                    flush_id_ex    = 1'b1;
                    state_next     = BRANCH_NEXT;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (ext_stall) begin
                    fetch_en  = 1'b0;
                    decode_en = 1'b0;
                end else if (flush_cnt == 16'd0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 16'd1;
                end
            end
            STALL: begin
                running   = 1'b1;
                stall_inc = 1'b1;
                if (!ext_stall)
                    state_next = RUN;
            end
            DRAIN: begin
                decode_en   = 1'b1;
                flush_if_id = 1'b1;
                if (branch_taken) begin
                    // An older instruction redirected, so the halt was wrong-path.
                    fetch_en       = 1'b1;
                    branch_flag    = 1'b1;
                    flush_id_ex    = 1'b1;
                    state_next     = BRANCH_NEXT;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (ext_stall) begin
                    decode_en = 1'b0;
                end else if (drain_cnt == 16'd0) begin
                    state_next = HALTED;
                end else begin
                    drain_cnt_next = drain_cnt - 16'd1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (start)
                    state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    assign branch_addr = branch_flag ? branch_target : 32'd0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer with a cycle-count reference
// model feeding an expected-output queue that a negedge monitor drains.
module tb_fetch_sequencer;
    localparam int FC = 2;
    localparam int DC = 3;
    localparam int CW = 4;
    localparam int VW = 39 + CW;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_FLUSH  = 2;
    localparam int M_STALL  = 3;
    localparam int M_DRAIN  = 4;
    localparam int M_HALTED = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, halt_detect, branch_taken, hazard_load, ext_stall;
    logic [31:0]   branch_target;
    logic          fetch_en, decode_en, flush_if_id, flush_id_ex, branch_flag;
    logic [31:0]   branch_addr;
    logic          running, halted;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .FLUSH_CYCLES (FC),
        .DRAIN_CYCLES (DC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt_detect   (halt_detect),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hazard_load   (hazard_load),
        .ext_stall     (ext_stall),
        .fetch_en      (fetch_en),
        .decode_en     (decode_en),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .branch_flag   (branch_flag),
        .branch_addr   (branch_addr),
        .running       (running),
        .halted        (halted),
        .stall_count   (stall_count)
    );

    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] mon_want, mon_got;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: current mode, cycles left in FLUSH/DRAIN, stall total.
    int mode   = M_IDLE;
    int left   = 0;
    int stalls = 0;

    task automatic step(input logic st, input logic hd, input logic bt,
                        input logic [31:0] tgt, input logic hl, input logic es,
                        input logic rs);
        logic f, d, fii, fie, bf, run, hlt;
        logic [31:0] ba;
        int sc, nmode;
        @(posedge clk);
        #1;
        start         = st;
        halt_detect   = hd;
        branch_taken  = bt;
        branch_target = tgt;
        hazard_load   = hl;
        ext_stall     = es;
        rst           = rs ? 1'b0 : 1'b1;
        f = 0; d = 0; fii = 0; fie = 0; bf = 0; run = 0; hlt = 0; ba = 32'd0;
        sc    = stalls;
        nmode = mode;
        if (rs) begin
            mode   = M_IDLE;
            left   = 0;
            stalls = 0;
            sc     = 0;
        end else begin
            run = (mode == M_RUN) || (mode == M_FLUSH) || (mode == M_STALL);
            if (bt && (mode == M_RUN || mode == M_FLUSH || mode == M_DRAIN)) begin
                bf = 1; ba = tgt; f = 1; d = 1; fii = 1; fie = 1;
                left  = FC;
                nmode = (FC == 1) ? M_RUN : M_FLUSH;
            end else begin
                case (mode)
                    M_IDLE:   if (st) nmode = M_RUN;
                    M_RUN: begin
                        if (es) nmode = M_STALL;
                        else if (hl) begin
                            fie = 1;
                            if (stalls < (1 << CW) - 1) stalls++;
                        end else if (hd) begin
                            d = 1; fii = 1; left = DC; nmode = M_DRAIN;
                        end else begin
                            f = 1; d = 1;
                        end
                    end
                    M_FLUSH: begin
                        fii = 1;
                        if (!es) begin
                            f = 1; d = 1; left--;
                            if (left == 0) nmode = M_RUN;
                        end
                    end
                    M_STALL: begin
                        if (stalls < (1 << CW) - 1) stalls++;
                        if (!es) nmode = M_RUN;
                    end
                    M_DRAIN: begin
                        fii = 1;
                        if (!es) begin
                            d = 1; left--;
                            if (left == 0) nmode = M_HALTED;
                        end
                    end
                    default: begin
                        hlt = 1;
                        if (st) nmode = M_RUN;
                    end
                endcase
            end
            mode = nmode;
        end
        exp_q.push_back({f, d, fii, fie, bf, ba, run, hlt, CW'(sc)});
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_want = exp_q.pop_front();
            mon_got  = {fetch_en, decode_en, flush_if_id, flush_id_ex, branch_flag,
                        branch_addr, running, halted, stall_count};
            n_checks++;
            if (mon_got === mon_want)
                n_pass++;
            else
                $display("FAIL outputs cycle %0d {fe,de,fii,fie,bf,addr,run,hlt,sc}: got %h want %h",
                         cyc, mon_got, mon_want);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks made", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 0; halt_detect = 0; branch_taken = 0;
        branch_target = 32'd0; hazard_load = 0; ext_stall = 0;

        // Reset, idle with noise ignored, then start
        step(0, 0, 0, 32'd0, 0, 0, 1);
        step(0, 0, 0, 32'd0, 0, 0, 1);
        step(0, 1, 1, 32'h1234, 1, 1, 0);
        step(1, 0, 0, 32'd0, 0, 0, 0);
        quiet(2);
        // Taken branch to 0x40
        step(0, 0, 1, 32'h40, 0, 0, 0);
        quiet(4);
        // One-cycle load-use bubble
        step(0, 0, 0, 32'd0, 1, 0, 0);
        quiet(2);
        // Five-cycle memory stall
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'd0, 0, 1, 0);
        quiet(3);
        // Halt drains to HALTED, start resumes
        step(0, 1, 0, 32'd0, 0, 0, 0);
        quiet(5);
        step(1, 0, 0, 32'd0, 0, 0, 0);
        quiet(2);
        // Halt cancelled by branch on the second drain cycle
        step(0, 1, 0, 32'd0, 0, 0, 0);
        quiet(1);
        step(0, 0, 1, 32'hDEAD_BEE0, 0, 0, 0);
        quiet(4);
        // Halt and hazard during flush are ignored; stall freezes the flush
        step(0, 0, 1, 32'h0000_0100, 0, 0, 0);
        step(0, 1, 0, 32'd0, 1, 0, 0);
        step(0, 0, 0, 32'd0, 0, 1, 0);
        step(0, 1, 0, 32'd0, 0, 0, 0);
        quiet(3);
        // Start outside IDLE/HALTED ignored
        step(1, 0, 0, 32'd0, 0, 0, 0);
        quiet(1);
        // Long stall saturates the counter, then reset mid-stall
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'd0, 0, 1, 0);
        step(0, 0, 0, 32'd0, 0, 1, 1);
        step(0, 0, 0, 32'd0, 0, 1, 0);
        step(1, 0, 0, 32'd0, 0, 0, 0);
        quiet(2);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 149) == 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
